fetch_queue: RTL

Parametrised instruction-fetch front end with a prefetch buffer. It replaces the bare PC register and single IF/ID latch of the 5-stage core, and sits between instruction memory and the decode stage. It runs ahead of decode into a DEPTH-entry queue, so decode stalls no longer freeze fetch. It also discards wrong-path instructions on a branch or jump redirect without needing per-stage flush wiring.

---
 rtl/fetch_pkg.sv | 13 +
 rtl/fifo_sync.sv | 69 ++++++
 rtl/fetch_queue.sv | 98 +++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared defaults and encodings for the instruction-fetch front end.
package fetch_pkg;

  localparam int unsigned DATA_W_DEFAULT   = 32;
  localparam int unsigned ADDR_W_DEFAULT   = 32;
  localparam int unsigned DEPTH_DEFAULT    = 4;
  localparam int unsigned PC_STEP_DEFAULT  = 1;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Instruction decode sees whenever the queue is empty.
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;

endpackage

// File: rtl/fifo_sync.sv
// Circular synchronous FIFO with synchronous clear and an occupancy count.
module fifo_sync #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr_i,
  input  logic                       wr_en_i,
  input  logic [WIDTH-1:0]           wr_data_i,
  input  logic                       rd_en_i,
  output logic [WIDTH-1:0]           rd_data_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_wr;
  logic             do_rd;

  // Pointer and count update; clear beats any push or pop in the same cycle.
  always_comb begin
    do_wr    = wr_en_i & (count_q != CNT_W'(DEPTH));
    do_rd    = rd_en_i & (count_q != '0);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_wr) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_rd) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({do_wr, do_rd})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array, intentionally not reset.
  always_ff @(posedge clk) begin
    if (do_wr && !clr_i) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign count_o   = count_q;

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: PC, credit-based prefetch into a small queue,
// and redirect handling that drops every wrong-path instruction.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned       DATA_W   = DATA_W_DEFAULT,
  parameter int unsigned       ADDR_W   = ADDR_W_DEFAULT,
  parameter int unsigned       DEPTH    = DEPTH_DEFAULT,
  parameter int unsigned       PC_STEP  = PC_STEP_DEFAULT,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       imem_req,
  output logic [ADDR_W-1:0]          imem_addr,
  input  logic [DATA_W-1:0]          imem_data,
  input  logic                       redirect_valid,
  input  logic [ADDR_W-1:0]          redirect_addr,
  input  logic                       deq_ready,
  output logic                       deq_valid,
  output logic [DATA_W-1:0]          deq_instr,
  output logic [ADDR_W-1:0]          deq_pc4,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned CNT_W = $clog2(DEPTH+1);
  localparam int unsigned CRD_W = CNT_W + 1;
  localparam int unsigned ENT_W = DATA_W + ADDR_W;

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
  logic              inflight_q, inflight_d;
  logic              deq_fire;
  logic [CRD_W-1:0]  credit_use;
  logic              fifo_wr;
  logic              fifo_rd;
  logic [ENT_W-1:0]  fifo_wdata;
  logic [ENT_W-1:0]  fifo_rdata;
  logic [CNT_W-1:0]  fifo_count;

  // Credit check, PC advance, redirect priority and head masking.
  always_comb begin
    deq_valid     = (fifo_count != '0);
    deq_fire      = deq_valid & deq_ready;
    // Slots already spoken for: stored + in flight - leaving this cycle.
    credit_use    = CRD_W'(fifo_count) + CRD_W'(inflight_q) - CRD_W'(deq_fire);
    imem_req      = rst & ~redirect_valid & (credit_use < CRD_W'(DEPTH));
    imem_addr     = fetch_pc_q;

    fetch_pc_d    = fetch_pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    if (redirect_valid) begin
      fetch_pc_d = redirect_addr;
    end else if (imem_req) begin
      inflight_d    = 1'b1;
      inflight_pc_d = fetch_pc_q;
      fetch_pc_d    = fetch_pc_q + ADDR_W'(PC_STEP);
    end

    // A redirect drops the response in flight and empties the queue.
    fifo_wr    = inflight_q & ~redirect_valid;
    fifo_rd    = deq_fire & ~redirect_valid;
    fifo_wdata = {imem_data, inflight_pc_q + ADDR_W'(PC_STEP)};

    deq_instr  = deq_valid ? fifo_rdata[ENT_W-1 -: DATA_W] : DATA_W'(NOP_INSTR);
    deq_pc4    = deq_valid ? fifo_rdata[ADDR_W-1:0] : '0;
    count      = fifo_count;
  end

  // Fetch PC and in-flight tracking registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

  fifo_sync #(
    .WIDTH (ENT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst),
    .clr_i     (redirect_valid),
    .wr_en_i   (fifo_wr),
    .wr_data_i (fifo_wdata),
    .rd_en_i   (fifo_rd),
    .rd_data_o (fifo_rdata),
    .count_o   (fifo_count)
  );

endmodule
